// File: rtl/poly_resampler.sv
// Rational L/M sample-rate converter: polyphase FIR with runtime-loadable taps,
// phase accumulator, saturation and registered req/ack handshakes on both sides.
module poly_resampler #(
    parameter int unsigned DWIDTH   = 16,
    parameter int unsigned COEF_W   = 16,
    parameter int unsigned L        = 160,
    parameter int unsigned L_LOG    = 8,
    parameter int unsigned M        = 147,
    parameter int unsigned TAPS     = 4,
    parameter int unsigned ADDR_LOG = 10,
    parameter int unsigned FRAC     = 15
) (
    input  logic                       clk,
    input  logic                       rst,
    output logic                       req_in,
    input  logic                       ack_in,
    input  logic signed [DWIDTH-1:0]   data_in,
    output logic                       req_out,
    input  logic                       ack_out,
    output logic signed [DWIDTH-1:0]   data_out,
    input  logic                       coef_we,
    input  logic [ADDR_LOG-1:0]        coef_addr,
    input  logic signed [COEF_W-1:0]   coef_data
);

    localparam int unsigned PROD_W = DWIDTH + COEF_W;
    localparam int unsigned ACC_W  = PROD_W + $clog2(TAPS);
    localparam int unsigned K_W    = (TAPS > 1) ? $clog2(TAPS) : 1;
    // One guard bit so phase + M can never wrap before the subtract loop.
    localparam int unsigned PH_W   = L_LOG + 1;
    localparam int unsigned NEED_W = PH_W;
    localparam int unsigned DEPTH  = L * TAPS;
    localparam logic signed [ACC_W-1:0] SAT_HI = {{(ACC_W-DWIDTH+1){1'b0}}, {(DWIDTH-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_LO = {{(ACC_W-DWIDTH+1){1'b1}}, {(DWIDTH-1){1'b0}}};

    typedef enum logic [2:0] {S_IN, S_MAC, S_OUT, S_ADD, S_ADV} state_t;

    state_t                     state_q, state_d;
    logic                       req_in_d, req_out_d;
    logic signed [DWIDTH-1:0]   dout_d;
    logic signed [DWIDTH-1:0]   x_q [TAPS];
    logic signed [DWIDTH-1:0]   x_d [TAPS];
    logic [PH_W-1:0]            phase_q, phase_d;
    logic [NEED_W-1:0]          need_q, need_d;
    logic [K_W-1:0]             k_q, k_d;
    logic [ADDR_LOG-1:0]        addr_q, addr_d;
    logic signed [ACC_W-1:0]    acc_q, acc_d;

    logic signed [COEF_W-1:0]   coef_mem [DEPTH];
    logic signed [PROD_W-1:0]   prod;
    logic signed [ACC_W-1:0]    acc_sum, shifted;
    logic signed [DWIDTH-1:0]   sat_val;

    // Coefficient store: not reset, writes blocked while the MAC reads it.
    always_ff @(posedge clk) begin
        if (coef_we && state_q != S_MAC && 32'(coef_addr) < DEPTH)
            coef_mem[coef_addr] <= coef_data;
    end

    always_comb begin
        prod    = PROD_W'(coef_mem[addr_q]) * PROD_W'(x_q[k_q]);
        acc_sum = acc_q + ACC_W'(prod);
        shifted = acc_sum >>> FRAC;
        if (shifted > SAT_HI)
            sat_val = DWIDTH'(SAT_HI);
        else if (shifted < SAT_LO)
            sat_val = DWIDTH'(SAT_LO);
        else
            sat_val = DWIDTH'(shifted);
    end

    always_comb begin
        state_d   = state_q;
        req_in_d  = req_in;
        req_out_d = req_out;
        dout_d    = data_out;
        x_d       = x_q;
        phase_d   = phase_q;
        need_d    = need_q;
        k_d       = k_q;
        addr_d    = addr_q;
        acc_d     = acc_q;
        case (state_q)
            S_IN: begin
                if (!req_in) begin
                    req_in_d = 1'b1;
                end else if (ack_in) begin
                    req_in_d = 1'b0;
                    for (int i = TAPS - 1; i > 0; i--) x_d[i] = x_q[i-1];
                    x_d[0] = data_in;
                    need_d = need_q - NEED_W'(1);
                    if (need_q == NEED_W'(1)) begin
                        state_d = S_MAC;
                        k_d     = '0;
                        addr_d  = ADDR_LOG'(phase_q);
                        acc_d   = '0;
                    end
                end
            end
            S_MAC: begin
                acc_d  = acc_sum;
                addr_d = addr_q + ADDR_LOG'(L);
                k_d    = k_q + K_W'(1);
                if (k_q == K_W'(TAPS - 1)) begin
                    dout_d  = sat_val;
                    state_d = S_OUT;
                end
            end
            S_OUT: begin
                if (!req_out) begin
                    req_out_d = 1'b1;
                end else if (ack_out) begin
                    req_out_d = 1'b0;
                    state_d   = S_ADD;
                end
            end
            S_ADD: begin
                phase_d = phase_q + PH_W'(M);
                state_d = S_ADV;
            end
            S_ADV: begin
                // One subtraction per cycle; each wrap consumes one more input.
                if (phase_q >= PH_W'(L)) begin
                    phase_d = phase_q - PH_W'(L);
                    need_d  = need_q + NEED_W'(1);
                end else if (need_q != '0) begin
                    state_d = S_IN;
                end else begin
                    state_d = S_MAC;
                    k_d     = '0;
                    addr_d  = ADDR_LOG'(phase_q);
                    acc_d   = '0;
                end
            end
            default: state_d = S_IN;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IN;
            req_in   <= 1'b0;
            req_out  <= 1'b0;
            data_out <= '0;
            for (int i = 0; i < TAPS; i++) x_q[i] <= '0;
            phase_q  <= '0;
            need_q   <= NEED_W'(1);
            k_q      <= '0;
            addr_q   <= '0;
            acc_q    <= '0;
        end else begin
            state_q  <= state_d;
            req_in   <= req_in_d;
            req_out  <= req_out_d;
            data_out <= dout_d;
            x_q      <= x_d;
            phase_q  <= phase_d;
            need_q   <= need_d;
            k_q      <= k_d;
            addr_q   <= addr_d;
            acc_q    <= acc_d;
        end
    end

endmodule

// File: tb/tb_poly_resampler.sv
// Directed bench for poly_resampler: three configurations (pass-through, 3/2, 2-tap)
// driven by queue-fed source/sink models on a shared clock and reset.
module tb_poly_resampler;

    logic clk = 1'b0;
    logic rst;
    logic req_in [3];
    logic ack_in [3];
    logic req_out [3];
    logic ack_out [3];
    logic coef_we [3];
    logic signed [15:0] data_in [3];
    logic signed [15:0] data_out [3];
    logic signed [15:0] coef_data [3];
    logic [9:0] coef_addr [3];

    logic signed [15:0] in_mem [3][16];
    logic signed [15:0] out_mem [3][16];
    logic signed [15:0] cap_d [3];
    int in_wr [3];
    int in_rd [3];
    int out_cnt [3];
    int out_inc [3][16];
    int cap_n [3];
    bit sink_en [3];
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    poly_resampler #(.DWIDTH(16), .COEF_W(16), .L(1), .L_LOG(8), .M(1), .TAPS(1),
                     .ADDR_LOG(10), .FRAC(0)) u_a (
        .clk(clk), .rst(rst), .req_in(req_in[0]), .ack_in(ack_in[0]), .data_in(data_in[0]),
        .req_out(req_out[0]), .ack_out(ack_out[0]), .data_out(data_out[0]),
        .coef_we(coef_we[0]), .coef_addr(coef_addr[0]), .coef_data(coef_data[0]));

    poly_resampler #(.DWIDTH(16), .COEF_W(16), .L(3), .L_LOG(8), .M(2), .TAPS(1),
                     .ADDR_LOG(10), .FRAC(0)) u_b (
        .clk(clk), .rst(rst), .req_in(req_in[1]), .ack_in(ack_in[1]), .data_in(data_in[1]),
        .req_out(req_out[1]), .ack_out(ack_out[1]), .data_out(data_out[1]),
        .coef_we(coef_we[1]), .coef_addr(coef_addr[1]), .coef_data(coef_data[1]));

    poly_resampler #(.DWIDTH(16), .COEF_W(16), .L(1), .L_LOG(8), .M(1), .TAPS(2),
                     .ADDR_LOG(10), .FRAC(0)) u_c (
        .clk(clk), .rst(rst), .req_in(req_in[2]), .ack_in(ack_in[2]), .data_in(data_in[2]),
        .req_out(req_out[2]), .ack_out(ack_out[2]), .data_out(data_out[2]),
        .coef_we(coef_we[2]), .coef_addr(coef_addr[2]), .coef_data(coef_data[2]));

    // Source and sink models; an ack held across a rising edge with req high is a transfer.
    always @(negedge clk) begin
        for (int g = 0; g < 3; g++) begin
            if (!rst) begin
                ack_in[g]  = 1'b0;
                ack_out[g] = 1'b0;
                data_in[g] = 16'sd0;
                in_rd[g]   = 0;
                out_cnt[g] = 0;
            end else begin
                if (ack_in[g]) in_rd[g]++;
                if (ack_out[g]) begin
                    out_mem[g][out_cnt[g] & 15] = cap_d[g];
                    out_inc[g][out_cnt[g] & 15] = cap_n[g];
                    out_cnt[g]++;
                end
                ack_in[g]  = req_in[g] && (in_rd[g] < in_wr[g]);
                data_in[g] = ack_in[g] ? in_mem[g][in_rd[g] & 15] : 16'sd0;
                ack_out[g] = req_out[g] && sink_en[g];
                if (ack_out[g]) begin
                    cap_d[g] = data_out[g];
                    cap_n[g] = in_rd[g];
                end
            end
        end
    end

    task automatic push(input int d, input int v);
        in_mem[d][in_wr[d] & 15] = 16'(v);
        in_wr[d]++;
    endtask

    task automatic write_coef(input int d, input int a, input int v);
        @(negedge clk);
        coef_we[d]   = 1'b1;
        coef_addr[d] = 10'(a);
        coef_data[d] = 16'(v);
        @(negedge clk);
        coef_we[d] = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        for (int g = 0; g < 3; g++) begin
            in_wr[g]   = 0;
            sink_en[g] = 1'b1;
        end
        repeat (2) @(negedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic wait_outs(input int d, input int n, output bit ok);
        ok = 1'b0;
        for (int t = 0; t < 300 && !ok; t++) begin
            @(negedge clk);
            #1;
            if (out_cnt[d] >= n) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int g = 0; g < 3; g++) begin
            coef_we[g] = 1'b0;
            coef_addr[g] = '0;
            coef_data[g] = '0;
            in_wr[g] = 0;
            sink_en[g] = 1'b1;
        end
        #1 rst = 1'b0;
        #2;
        for (int g = 0; g < 3; g++) begin
            total++;
            if (req_in[g] !== 1'b0 || req_out[g] !== 1'b0 || data_out[g] !== 16'sd0) begin
                bad++;
                $display("FAIL reset_async[%0d] got req_in=%b req_out=%b data_out=%0d want 0 0 0",
                         g, req_in[g], req_out[g], data_out[g]);
            end
        end
        repeat (2) @(negedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        #1;
        for (int g = 0; g < 3; g++) begin
            total++;
            if (req_in[g] !== 1'b1) begin
                bad++;
                $display("FAIL reset_first_req[%0d] got req_in=%b want 1", g, req_in[g]);
            end
        end
        write_coef(0, 0, 1);
        write_coef(1, 0, 1);
        write_coef(1, 1, 2);
        write_coef(1, 2, 3);
        write_coef(2, 0, 1);
        write_coef(2, 1, 1);
    endtask

    task automatic test_pass_through();
        int exp_v[3] = '{5, -7, 32767};
        bit ok;
        push(0, 5); push(0, -7); push(0, 32767);
        wait_outs(0, 3, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL pass_timeout got=%0d outputs want 3", out_cnt[0]); end
        for (int i = 0; i < 3; i++) begin
            total++;
            if (out_mem[0][i] !== 16'(exp_v[i]) || out_inc[0][i] !== i + 1) begin
                bad++;
                $display("FAIL pass_out[%0d] got=%0d inputs=%0d want=%0d inputs=%0d",
                         i, out_mem[0][i], out_inc[0][i], exp_v[i], i + 1);
            end
        end
    endtask

    task automatic test_ratio();
        int exp_v[5] = '{10, 30, 40, 30, 90};
        int exp_n[5] = '{1, 1, 2, 3, 3};
        bit ok;
        push(1, 10); push(1, 20); push(1, 30);
        wait_outs(1, 5, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL ratio_timeout got=%0d outputs want 5", out_cnt[1]); end
        for (int i = 0; i < 5; i++) begin
            total++;
            if (out_mem[1][i] !== 16'(exp_v[i]) || out_inc[1][i] !== exp_n[i]) begin
                bad++;
                $display("FAIL ratio_out[%0d] got=%0d inputs=%0d want=%0d inputs=%0d",
                         i, out_mem[1][i], out_inc[1][i], exp_v[i], exp_n[i]);
            end
        end
    endtask

    task automatic test_saturation();
        int exp_v[4] = '{30000, 32767, -30000, -32768};
        bit ok;
        for (int r = 0; r < 2; r++) begin
            do_reset();
            push(2, r == 0 ? 30000 : -30000);
            push(2, r == 0 ? 30000 : -30000);
            wait_outs(2, 2, ok);
            total++;
            if (!ok) begin bad++; $display("FAIL sat_timeout[%0d] got=%0d outputs want 2", r, out_cnt[2]); end
            for (int i = 0; i < 2; i++) begin
                total++;
                if (out_mem[2][i] !== 16'(exp_v[2*r+i])) begin
                    bad++;
                    $display("FAIL sat_out[%0d] got=%0d want=%0d", 2*r+i, out_mem[2][i], exp_v[2*r+i]);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        do_reset();
        sink_en[2] = 1'b0;
        push(2, 100);
        for (int t = 0; t < 100 && req_out[2] !== 1'b1; t++) begin @(negedge clk); #1; end
        total++;
        if (req_out[2] !== 1'b1) begin bad++; $display("FAIL bp_timeout got req_out=%b want 1", req_out[2]); end
        push(2, 200);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            #1;
            total++;
            if (req_out[2] !== 1'b1 || data_out[2] !== 16'sd100 || req_in[2] !== 1'b0 || in_rd[2] !== 1) begin
                bad++;
                $display("FAIL bp_hold[%0d] got req_out=%b data=%0d req_in=%b inputs=%0d want 1 100 0 1",
                         c, req_out[2], data_out[2], req_in[2], in_rd[2]);
            end
        end
        sink_en[2] = 1'b1;
        wait_outs(2, 2, ok);
        total++;
        if (!ok || out_mem[2][0] !== 16'sd100 || out_mem[2][1] !== 16'sd300) begin
            bad++;
            $display("FAIL bp_release got=%0d,%0d want=100,300", out_mem[2][0], out_mem[2][1]);
        end
    endtask

    task automatic test_async_reset();
        bit ok;
        do_reset();
        push(2, 500);
        wait_outs(2, 1, ok);
        push(2, 600);
        for (int t = 0; t < 100 && in_rd[2] < 2; t++) begin @(negedge clk); #1; end
        total++;
        if (in_rd[2] !== 2 || data_out[2] !== 16'sd500) begin
            bad++;
            $display("FAIL arst_setup got inputs=%0d data=%0d want 2 500", in_rd[2], data_out[2]);
        end
        #2 rst = 1'b0;
        for (int g = 0; g < 3; g++) in_wr[g] = 0;
        #1;
        total++;
        if (req_in[2] !== 1'b0 || req_out[2] !== 1'b0 || data_out[2] !== 16'sd0) begin
            bad++;
            $display("FAIL arst_mid_mac got req_in=%b req_out=%b data=%0d want 0 0 0",
                     req_in[2], req_out[2], data_out[2]);
        end
        repeat (2) @(negedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        #1;
        total++;
        if (req_in[2] !== 1'b1 || req_out[2] !== 1'b0) begin
            bad++;
            $display("FAIL arst_first_action got req_in=%b req_out=%b want 1 0", req_in[2], req_out[2]);
        end
        push(2, 7); push(2, 3);
        wait_outs(2, 2, ok);
        total++;
        if (!ok || out_mem[2][0] !== 16'sd7 || out_mem[2][1] !== 16'sd10) begin
            bad++;
            $display("FAIL arst_after got=%0d,%0d want=7,10", out_mem[2][0], out_mem[2][1]);
        end
    endtask

    task automatic test_coef_guard();
        bit ok;
        do_reset();
        sink_en[0] = 1'b0;
        push(0, 9);
        for (int t = 0; t < 100 && in_rd[0] < 1; t++) begin @(negedge clk); #1; end
        coef_we[0] = 1'b1; coef_addr[0] = 10'd0; coef_data[0] = 16'sd100;
        @(negedge clk);
        coef_we[0] = 1'b0;
        sink_en[0] = 1'b1;
        wait_outs(0, 1, ok);
        total++;
        if (!ok || out_mem[0][0] !== 16'sd9) begin
            bad++;
            $display("FAIL guard_first got=%0d want=9", out_mem[0][0]);
        end
        sink_en[0] = 1'b0;
        push(0, 5);
        for (int t = 0; t < 100 && !(req_out[0] === 1'b1 && in_rd[0] == 2); t++) begin @(negedge clk); #1; end
        total++;
        if (req_out[0] !== 1'b1 || data_out[0] !== 16'sd5) begin
            bad++;
            $display("FAIL guard_mac_write_dropped got req_out=%b data=%0d want 1 5", req_out[0], data_out[0]);
        end
        coef_we[0] = 1'b1; coef_addr[0] = 10'd0; coef_data[0] = 16'sd2;
        @(negedge clk);
        coef_we[0] = 1'b0;
        sink_en[0] = 1'b1;
        push(0, 7);
        wait_outs(0, 3, ok);
        total++;
        if (!ok || out_mem[0][1] !== 16'sd5 || out_mem[0][2] !== 16'sd14) begin
            bad++;
            $display("FAIL guard_out_write got=%0d,%0d want=5,14", out_mem[0][1], out_mem[0][2]);
        end
    endtask

    initial begin
        test_reset();
        test_pass_through();
        test_ratio();
        test_saturation();
        test_backpressure();
        test_async_reset();
        test_coef_guard();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
